// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - core request ports and shared RAM port bundle for memory_arbiter
interface memory_arbiter_if #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
);
    logic [CPUS-1:0]             iREN;
    logic [CPUS-1:0]             dREN;
    logic [CPUS-1:0]             dWEN;
    logic [CPUS-1:0][ADDR_W-1:0] iaddr;
    logic [CPUS-1:0][ADDR_W-1:0] daddr;
    logic [CPUS-1:0][ADDR_W-1:0] dstore;
    logic [1:0]                  ramstate;
    logic [ADDR_W-1:0]           ramload;
    logic [CPUS-1:0]             iwait;
    logic [CPUS-1:0]             dwait;
    logic [CPUS-1:0][ADDR_W-1:0] iload;
    logic [CPUS-1:0][ADDR_W-1:0] dload;
    logic [ADDR_W-1:0]           ramaddr;
    logic [ADDR_W-1:0]           ramstore;
    logic                        ramREN;
    logic                        ramWEN;

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramstate, ramload,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-core RAM arbiter, round-robin grant FSM; MEMARB_STATS_EN adds grants_cnt
module memory_arbiter #(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
`ifdef MEMARB_STATS_EN
    output logic [CPUS-1:0][15:0] grants_cnt,
`endif
    memory_arbiter_if.slave       bus
);
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    typedef enum logic {KIND_INSTR, KIND_DATA} kind_t;

    state_t state_q, state_d;
    kind_t  grant_kind_q, grant_kind_d;
    logic   grant_core_q, grant_core_d;
    logic   last_core_q, last_core_d;
    logic   pick_core;

    logic [CPUS-1:0] data_req;
    logic [CPUS-1:0] any_req;
    logic            withdrawn;

    assign data_req = bus.dREN | bus.dWEN;
    assign any_req  = data_req | bus.iREN;

    // The granted core dropped the enable of the kind it was granted for
    assign withdrawn = (grant_kind_q == KIND_DATA) ? ~data_req[grant_core_q]
                                                   : ~bus.iREN[grant_core_q];

    assign bus.iload = {CPUS{bus.ramload}};
    assign bus.dload = {CPUS{bus.ramload}};

    // Arbitrate in IDLE, drive the RAM port from the registered grant in GRANT
    always_comb begin
        state_d      = state_q;
        grant_core_d = grant_core_q;
        grant_kind_d = grant_kind_q;
        last_core_d  = last_core_q;
        pick_core    = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        case (state_q)
            ST_IDLE: begin
                if (|any_req) begin
                    if (&any_req) begin
                        pick_core = ~last_core_q;
                    end else begin
                        pick_core = any_req[1];
                    end
                    grant_core_d = pick_core;
                    grant_kind_d = data_req[pick_core] ? KIND_DATA : KIND_INSTR;
                    state_d      = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_kind_q == KIND_DATA) begin
                    bus.ramaddr  = bus.daddr[grant_core_q];
                    bus.ramstore = bus.dstore[grant_core_q];
                    bus.ramWEN   = bus.dWEN[grant_core_q];
                    bus.ramREN   = bus.dREN[grant_core_q] & ~bus.dWEN[grant_core_q];
                end else begin
                    bus.ramaddr  = bus.iaddr[grant_core_q];
                    bus.ramREN   = ~withdrawn;
                end
                if (withdrawn) begin
                    state_d = ST_IDLE;
                end else if (bus.ramstate == RAM_ACCESS) begin
                    if (grant_kind_q == KIND_DATA) begin
                        bus.dwait[grant_core_q] = 1'b0;
                    end else begin
                        bus.iwait[grant_core_q] = 1'b0;
                    end
                    state_d     = ST_IDLE;
                    last_core_d = grant_core_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and grant registers; last_core resets to 1 so core 0 wins the first tie
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            grant_core_q <= 1'b0;
            grant_kind_q <= KIND_INSTR;
            last_core_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_core_q <= grant_core_d;
            grant_kind_q <= grant_kind_d;
            last_core_q  <= last_core_d;
        end
    end

`ifdef MEMARB_STATS_EN
    logic                  xfer_done;
    logic [CPUS-1:0][15:0] grants_cnt_q, grants_cnt_d;

    assign xfer_done  = (state_q == ST_GRANT) && !withdrawn && (bus.ramstate == RAM_ACCESS);
    assign grants_cnt = grants_cnt_q;

    // Count completed transfers per core, wrapping at 16 bits
    always_comb begin
        grants_cnt_d = grants_cnt_q;
        if (xfer_done) begin
            grants_cnt_d[grant_core_q] = grants_cnt_q[grant_core_q] + 16'd1;
        end
    end

    // Completion counter registers
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            grants_cnt_q <= '0;
        end else begin
            grants_cnt_q <= grants_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard testbench for memory_arbiter
module tb_memory_arbiter;
    logic clk;
    logic nrst;

    memory_arbiter_if #(.CPUS(2), .ADDR_W(32)) bus ();

`ifdef MEMARB_STATS_EN
    logic [1:0][15:0] grants_cnt;
`endif

    memory_arbiter #(.CPUS(2), .ADDR_W(32)) dut (
        .CLK       (clk),
        .nRST      (nrst),
`ifdef MEMARB_STATS_EN
        .grants_cnt(grants_cnt),
`endif
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        core;
        logic        data;
        logic        write;
        logic [31:0] addr;
        logic [31:0] store;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt0 = 0;
    int   cnt1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic core, input logic data, input logic write,
                            input logic [31:0] addr, input logic [31:0] store);
        exp_t e;
        e.core = core; e.data = data; e.write = write; e.addr = addr; e.store = store;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        bus.ramload = $urandom;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: any low wait is a completion that must match the oldest expected transfer
    always @(negedge clk) begin
        if (nrst && (bus.iwait != 2'b11 || bus.dwait != 2'b11)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", {bus.iwait, bus.dwait}, 4'hF);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_iwait", bus.iwait, mon_e.data ? 2'b11 : (mon_e.core ? 2'b01 : 2'b10));
                check("sb_dwait", bus.dwait, !mon_e.data ? 2'b11 : (mon_e.core ? 2'b01 : 2'b10));
                check("sb_addr", bus.ramaddr, mon_e.addr);
                check("sb_wen", bus.ramWEN, mon_e.write);
                check("sb_ren", bus.ramREN, !mon_e.write);
                if (mon_e.write) check("sb_store", bus.ramstore, mon_e.store);
                if (mon_e.data) check("sb_dload", bus.dload[mon_e.core], bus.ramload);
                else            check("sb_iload", bus.iload[mon_e.core], bus.ramload);
                if (mon_e.core) cnt1++; else cnt0++;
            end
        end
    end

    initial begin
        nrst = 1'b0;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        bus.ramstate = 2'b00; bus.ramload = '0;

        // Reset held with instruction requests pending
        bus.iREN = 2'b11;
        bus.iaddr[0] = 32'h0000_0100;
        bus.iaddr[1] = 32'h0000_0200;
        cyc(); cyc(); smp();
        check("rst_ren", bus.ramREN, 1'b0);
        check("rst_wen", bus.ramWEN, 1'b0);
        check("rst_iwait", bus.iwait, 2'b11);
        check("rst_dwait", bus.dwait, 2'b11);
        check("rst_addr", bus.ramaddr, 32'h0);
        cyc(); nrst = 1'b1;
        cyc(); smp();
        check("first_ren", bus.ramREN, 1'b1);
        check("first_addr", bus.ramaddr, 32'h0000_0100);
        check("first_iwait_free", bus.iwait, 2'b11);
        cyc(); bus.ramstate = 2'b10; bus.iREN = 2'b01;
        push_exp(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
        smp();
        cyc(); bus.iREN = 2'b00; bus.ramstate = 2'b00;
        smp();
        check("idle_ren", bus.ramREN, 1'b0);
        check("idle_addr", bus.ramaddr, 32'h0);

        // Data beats instruction within core 0
        cyc(); bus.iREN = 2'b01; bus.dREN = 2'b01; bus.daddr[0] = 32'h0000_0080; bus.ramstate = 2'b10;
        push_exp(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
        push_exp(1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
        cyc(); smp();
        check("prio_dwait", bus.dwait, 2'b10);
        check("prio_iwait", bus.iwait, 2'b11);
        cyc(); bus.dREN = 2'b00;
        smp();
        check("prio_idle_ren", bus.ramREN, 1'b0);
        check("prio_idle_iwait", bus.iwait, 2'b11);
        cyc(); smp();
        check("prio_instr_iwait", bus.iwait, 2'b10);
        cyc(); bus.iREN = 2'b00; bus.ramstate = 2'b00;

        // Core 1 write with two BUSY cycles
        cyc(); bus.dWEN = 2'b10; bus.daddr[1] = 32'h0000_0040; bus.dstore[1] = 32'hDEAD_BEEF; bus.ramstate = 2'b01;
        cyc(); smp();
        check("wr_wen", bus.ramWEN, 1'b1);
        check("wr_ren", bus.ramREN, 1'b0);
        check("wr_addr", bus.ramaddr, 32'h0000_0040);
        check("wr_store", bus.ramstore, 32'hDEAD_BEEF);
        check("wr_busy1_dwait", bus.dwait, 2'b11);
        cyc(); smp();
        check("wr_busy2_dwait", bus.dwait, 2'b11);
        cyc(); bus.ramstate = 2'b10;
        push_exp(1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        smp();
        check("wr_access_dwait", bus.dwait, 2'b01);
        cyc(); bus.dWEN = 2'b00; bus.ramstate = 2'b00;
        smp();
        check("wr_idle_wen", bus.ramWEN, 1'b0);
        check("wr_idle_dwait", bus.dwait, 2'b11);
        check("wr_idle_store", bus.ramstore, 32'h0);

        // Round-robin with both cores reading continuously
        cyc(); bus.dREN = 2'b11; bus.daddr[0] = 32'h0000_0300; bus.daddr[1] = 32'h0000_0400; bus.ramstate = 2'b10;
        for (int k = 0; k < 4; k++) begin
            push_exp(k[0], 1'b1, 1'b0, k[0] ? 32'h0000_0400 : 32'h0000_0300, 32'h0);
        end
        for (int k = 1; k < 8; k++) begin
            cyc(); smp();
            if (k % 2 == 1) begin
                check("rr_grant_ren", bus.ramREN, 1'b1);
                check("rr_grant_addr", bus.ramaddr, (k == 1 || k == 5) ? 32'h0000_0300 : 32'h0000_0400);
            end else begin
                check("rr_idle_ren", bus.ramREN, 1'b0);
            end
        end
        cyc(); bus.dREN = 2'b00; bus.ramstate = 2'b00;
        smp();
        check("rr_end_ren", bus.ramREN, 1'b0);

        // Withdrawal during BUSY, then pending core 1 request is served
        cyc(); bus.dREN = 2'b01; bus.daddr[0] = 32'h0000_0500; bus.ramstate = 2'b01;
        cyc(); bus.iREN = 2'b10; bus.iaddr[1] = 32'h0000_0600;
        smp();
        check("wd_grant_ren", bus.ramREN, 1'b1);
        check("wd_grant_addr", bus.ramaddr, 32'h0000_0500);
        cyc(); bus.dREN = 2'b00;
        smp();
        check("wd_drop_ren", bus.ramREN, 1'b0);
        check("wd_drop_dwait", bus.dwait, 2'b11);
        cyc(); smp();
        check("wd_idle_ren", bus.ramREN, 1'b0);
        cyc(); smp();
        check("wd_next_ren", bus.ramREN, 1'b1);
        check("wd_next_addr", bus.ramaddr, 32'h0000_0600);
        cyc(); bus.ramstate = 2'b10;
        push_exp(1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0);
        smp();
        cyc(); bus.iREN = 2'b00; bus.ramstate = 2'b00;
        smp();
        check("sb_drain", exp_q.size(), 0);

`ifdef MEMARB_STATS_EN
        check("stats_c0", grants_cnt[0], cnt0);
        check("stats_c1", grants_cnt[1], cnt1);
        cyc(); nrst = 1'b0;
        cyc(); smp();
        check("stats_rst", grants_cnt, 32'h0);
        cyc(); nrst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Two-core RAM arbiter and sequencer. It sits between the per-core instruction and data cache request ports and the single shared RAM port. It replaces the combinational single-core pass-through with a registered grant FSM, round-robin fairness between cores and data-over-instruction priority within a core. The RAM-side protocol is unchanged: REN/WEN with address and store, and completion when ramstate is ACCESS.

Parameters:
CPUS, 2, number of cores; only 2 is supported.
ADDR_W, 32, address and data word width.

Ports:
CLK  input  1  system clock; all state updates on the rising edge
nRST  input  1  synchronous active-low reset, sampled on the CLK rising edge
iREN  input  CPUS  per-core instruction read request
dREN  input  CPUS  per-core data read request
dWEN  input  CPUS  per-core data write request
iaddr  input  CPUS x ADDR_W  per-core instruction address
daddr  input  CPUS x ADDR_W  per-core data address
dstore  input  CPUS x ADDR_W  per-core write data
ramstate  input  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11
ramload  input  ADDR_W  RAM read data
iwait  output  CPUS  per-core instruction wait; 0 = transfer completes this cycle
dwait  output  CPUS  per-core data wait; 0 = transfer completes this cycle
iload  output  CPUS x ADDR_W  ramload broadcast to all cores
dload  output  CPUS x ADDR_W  ramload broadcast to all cores
ramaddr  output  ADDR_W  address to RAM
ramstore  output  ADDR_W  write data to RAM
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable

Behaviour:
- Reset (nRST=0 at a rising edge): state=IDLE, grant cleared, last_core=1 so core 0 wins the first tie. ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait=1, all dwait=1.
- Requester kind per core c: DATA if dREN[c]|dWEN[c]; otherwise INSTR if iREN[c]; otherwise none. Data always beats instruction within a core.
- If dREN and dWEN are both high for a core, treat it as a write.
- IDLE: sample requests. If exactly one core requests, grant that core. If both request, grant the core != last_core. Register grant_core and grant_kind, then go to GRANT. With no request, stay in IDLE.
- GRANT: drive the RAM port from the registered grant only.
  - DATA: ramaddr=daddr[g], ramstore=dstore[g], ramWEN=dWEN[g], ramREN=dREN[g]&~dWEN[g].
  - INSTR: ramaddr=iaddr[g], ramREN=1, ramWEN=0.
- In GRANT with ramstate==ACCESS: the granted wait (dwait[g] or iwait[g]) is 0 combinationally in that cycle. Next state is IDLE and last_core<=g.
- All non-granted waits stay 1 at all times. Arbitration latency is 1 cycle: a request first seen in cycle N has the RAM port driven from cycle N+1.
- FREE, BUSY or ERROR in GRANT: hold GRANT with waits at 1. ERROR is not retried or flagged.
- Request withdrawn in GRANT (the granted kind's enable drops for core g): deassert ramREN/ramWEN in that same cycle, return to IDLE, and leave last_core unchanged.
- A new request from the granted core is never chained. It always passes through IDLE, so back-to-back transfers take at least 2 cycles each.
- Any request change on a non-granted port during GRANT has no effect until IDLE.
- Outputs not driven in IDLE hold the reset values: REN=WEN=0, waits=1. ramaddr and ramstore hold 0.

Optional Feature:
MEMARB_STATS_EN: when defined, adds output grants_cnt (CPUS x 16). Each counter increments on every completed transfer (ACCESS in GRANT) for that core, wraps 0xFFFF->0, and clears on reset. When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold nRST=0 for 2 cycles with iREN=2'b11 -> ramREN=0, iwait=2'b11, dwait=2'b11. Release -> core 0 instruction granted the next cycle with ramaddr=iaddr[0].
- Single data write: core1 dWEN=1, daddr=0x0000_0040, dstore=0xDEAD_BEEF, ramstate BUSY 2 cycles then ACCESS -> ramWEN=1, ramaddr=0x40, ramstore=0xDEADBEEF. dwait[1]=0 only in the ACCESS cycle, then IDLE.
- Intra-core priority: core0 iREN=1 and dREN=1 with daddr=0x80 -> data is served first (dwait[0]=0 at ACCESS) with iwait[0]=1 throughout. Instruction is served on the next grant.
- Round-robin: both cores hold dREN continuously with ramstate=ACCESS -> grant sequence core0, core1, core0, core1. Each completion is separated by one IDLE cycle.
- Withdrawal: core0 dREN granted, ramstate=BUSY, then dREN drops -> ramREN=0 that cycle, IDLE next cycle, and a pending core1 request is granted after that.
- MEMARB_STATS_EN: 3 completions on core0 and 1 on core1 -> grants_cnt[0]=3, grants_cnt[1]=1. Preload the counter to 0xFFFF, complete one transfer -> counter reads 0.
